odetojoy_player: RTL and testbench
==================================

// Module: odetojoy_player
// PURPOSE
//   Autonomous melody generator for the FPGA piano: plays "Ode to Joy" as a timed stream of
//   4-bit note codes on the same note bus the keyboard decoder and the odetojoy recognizer use.
//   Each melody note is held for a fixed duration, then followed by a rest (none).
//   This gives the recognizer exactly the note/none alternation it expects. Used for demo mode
//   and as a loopback stimulus source for recognizer checks.
// PARAMETERS
//   NOTE_CYCLES  50_000_000  clock cycles each melody note is driven (>=1)
//   GAP_CYCLES   10_000_000  clock cycles of none after each note (>=1; 0 is illegal)
//   CNT_W        26          width of the duration counter; must hold max(NOTE_CYCLES,GAP_CYCLES)
//   LOOP         0           1: restart at note 0 after the final gap; 0: stop and pulse done
// PORTS
//   CLK      in   1  system clock
//   RESET    in   1  synchronous, active-high reset
//   start    in   1  level/pulse; sampled only in IDLE, begins playback at note index 0
//   stop     in   1  abort playback; return to IDLE
//   pause    in   1  freeze the counter, state and note output while high
//   note     out  4  note code (C4, D, E, F, G, none from parameters.v); registered
//   playing  out  1  high in NOTE or GAP state
//   idx      out  4  index (0..14) of the current melody note
//   done     out  1  one-cycle pulse when a non-looping playback completes
// BEHAVIOUR
//   Melody ROM, idx 0..14: E E F G G F E D C4 C4 D E E D D (15 entries, combinational case).
//   Reset, applied on a CLK edge while RESET=1: state=IDLE, note=none, playing=0, idx=0,
//     done=0, counter=0. RESET overrides all other inputs, including in mid-song.
//   FSM states are IDLE, NOTE and GAP. All outputs are registered.
//   IDLE:
//     - start=1 and stop=0 at edge t: state goes to NOTE, idx=0, and note=ROM[0] is visible
//       from cycle t+1. Latency is 1 cycle.
//   NOTE:
//     - note=ROM[idx] for exactly NOTE_CYCLES cycles (counter counts 0..NOTE_CYCLES-1).
//     - Then the state goes to GAP, note=none and the counter clears.
//   GAP:
//     - note=none for exactly GAP_CYCLES cycles.
//     - If idx<14: idx increments, the state goes to NOTE and note=ROM[idx+1].
//     - If idx==14 and LOOP=1: idx wraps to 0, the state goes to NOTE and note=E. There is no
//       done pulse and no IDLE cycle.
//     - If idx==14 and LOOP=0: the state goes to IDLE, note=none, playing=0, idx=0 and done=1
//       for exactly 1 cycle.
//   Arithmetic rules:
//     - The counter compares against NOTE_CYCLES-1 / GAP_CYCLES-1.
//     - idx wraps mod 15, never 15.
//   Control inputs:
//     - start while playing is ignored; it does not restart the song.
//     - stop=1 in any state: next cycle IDLE, note=none, playing=0, idx=0, counter=0, done=0.
//     - stop and start high together: stop wins and the block stays or goes IDLE.
//     - pause=1: state, idx, counter and note hold their values. Resume continues the remaining
//       duration exactly.
//     - stop overrides pause.
//     - pause in IDLE has no effect, and start is still honoured.
//   Full non-looping song length: 15*(NOTE_CYCLES+GAP_CYCLES) cycles with playing=1.
// TESTING  (bench uses NOTE_CYCLES=4, GAP_CYCLES=2, unless noted)
//   1 RESET then start pulse at cycle 0 -> note=E cycles 1-4, none 5-6, E 7-10, F 13-16, ...;
//     last D cycles 85-88, none 89-90, done=1 only in cycle 91, playing=0 from cycle 91.
//   2 Loopback into odetojoy recognizer, same CLK/RESET -> after playback, the recognizer
//     state passes 6'b011110 and returns to 0. The player never drives two equal notes without
//     a none in between.
//   3 pause=1 for 10 cycles starting at the 2nd cycle of idx 3 (G) -> note stays G for the
//     whole pause. It is then held 3 more cycles after release, and the total song length grows
//     by exactly 10.
//   4 stop in the middle of idx 7 (D), with start held high in the same cycle -> next cycle
//     note=none, playing=0, idx=0. A later start alone replays from E.
//   5 LOOP=1 -> after idx 14's gap, note=E and idx=0 with no idle cycle, and done is never
//     asserted.
//   6 RESET=1 for 1 cycle during the GAP of idx 5 -> all outputs reach their reset values on
//     the next cycle, and no done pulse occurs. Asynchronous RESET glitches between edges have
//     no effect.

Source files
------------

// File: rtl/odetojoy_player.sv
// Autonomous "Ode to Joy" melody generator for the note bus.
// Each note is driven for NOTE_CYCLES cycles and is then followed by GAP_CYCLES of none.
module odetojoy_player #(
   parameter int          NOTE_CYCLES = 50_000_000,
   parameter int          GAP_CYCLES  = 10_000_000,
   parameter int          CNT_W       = 26,
   parameter bit          LOOP        = 1'b0,
   parameter logic [3:0]  NOTE_NONE   = 4'd0,
   parameter logic [3:0]  NOTE_C4     = 4'd1,
   parameter logic [3:0]  NOTE_D      = 4'd2,
   parameter logic [3:0]  NOTE_E      = 4'd3,
   parameter logic [3:0]  NOTE_F      = 4'd4,
   parameter logic [3:0]  NOTE_G      = 4'd5
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   output logic [3:0] note,
   output logic       playing,
   output logic [3:0] idx,
   output logic       done
);

   typedef enum logic [1:0] {ST_IDLE, ST_NOTE, ST_GAP} state_t;

   localparam logic [3:0]       LAST_IDX = 4'd14;
   localparam logic [CNT_W-1:0] NOTE_END = CNT_W'(NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       note_q, note_d;
   logic             playing_q, playing_d;
   logic             done_q, done_d;

   function automatic logic [3:0] melody_note(input logic [3:0] i);
      case (i)
         4'd0, 4'd1, 4'd6, 4'd11, 4'd12: melody_note = NOTE_E;
         4'd2, 4'd5:                     melody_note = NOTE_F;
         4'd3, 4'd4:                     melody_note = NOTE_G;
         4'd7, 4'd10, 4'd13, 4'd14:      melody_note = NOTE_D;
         4'd8, 4'd9:                     melody_note = NOTE_C4;
         default:                        melody_note = NOTE_NONE;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      note_d    = note_q;
      playing_d = playing_q;
      done_d    = 1'b0;

      if (stop) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         idx_d     = '0;
         note_d    = NOTE_NONE;
         playing_d = 1'b0;
      end else if (pause && state_q != ST_IDLE) begin
         // Everything holds so the remaining duration resumes exactly.
         done_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d   = ST_NOTE;
                  cnt_d     = '0;
                  idx_d     = '0;
                  note_d    = melody_note(4'd0);
                  playing_d = 1'b1;
               end
            end
            ST_NOTE: begin
               if (cnt_q == NOTE_END) begin
                  state_d = ST_GAP;
                  cnt_d   = '0;
                  note_d  = NOTE_NONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_END) begin
                  cnt_d = '0;
                  if (idx_q != LAST_IDX) begin
                     state_d = ST_NOTE;
                     idx_d   = idx_q + 4'd1;
                     note_d  = melody_note(idx_q + 4'd1);
                  end else if (LOOP) begin
                     state_d = ST_NOTE;
                     idx_d   = '0;
                     note_d  = melody_note(4'd0);
                  end else begin
                     state_d   = ST_IDLE;
                     idx_d     = '0;
                     note_d    = NOTE_NONE;
                     playing_d = 1'b0;
                     done_d    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               idx_d     = '0;
               note_d    = NOTE_NONE;
               playing_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         note_q    <= NOTE_NONE;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         note_q    <= note_d;
         playing_q <= playing_d;
         done_q    <= done_d;
      end
   end

   assign note    = note_q;
   assign playing = playing_q;
   assign idx     = idx_q;
   assign done    = done_q;

endmodule

// File: tb/tb_odetojoy_player.sv
// Scoreboard bench for odetojoy_player: expected per-cycle outputs are queued as stimulus
// is applied and compared one cycle per step, for a one-shot and a looping instance.
module tb_odetojoy_player;

   localparam int NC = 4;
   localparam int GC = 2;
   localparam int SONG = 15 * (NC + GC);

   localparam logic [3:0] N_NONE = 4'd0, N_C4 = 4'd1, N_D = 4'd2,
                          N_E = 4'd3, N_F = 4'd4, N_G = 4'd5;

   typedef struct packed {
      logic [3:0] note;
      logic       playing;
      logic [3:0] idx;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop, pause, start_l, stop_l;
   logic [3:0] note, idx, note_l, idx_l;
   logic       playing, done, playing_l, done_l;

   exp_t exp_q[$];
   exp_t exp_l_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic [3:0] melody [15] = '{N_E, N_E, N_F, N_G, N_G, N_F, N_E, N_D,
                               N_C4, N_C4, N_D, N_E, N_E, N_D, N_D};

   always #5 clk = ~clk;

   odetojoy_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .CNT_W(4), .LOOP(1'b0)) u_dut (
      .CLK(clk), .RESET(rst), .start(start), .stop(stop), .pause(pause),
      .note(note), .playing(playing), .idx(idx), .done(done)
   );

   odetojoy_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .CNT_W(4), .LOOP(1'b1)) u_loop (
      .CLK(clk), .RESET(rst), .start(start_l), .stop(stop_l), .pause(1'b0),
      .note(note_l), .playing(playing_l), .idx(idx_l), .done(done_l)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Expected outputs in cycle k (1-based) after a start edge, no pause.
   function automatic exp_t song_entry(input int k);
      exp_t e;
      int   i = (k - 1) / (NC + GC);
      int   p = (k - 1) % (NC + GC);
      e.note    = (p < NC) ? melody[i] : N_NONE;
      e.playing = 1'b1;
      e.idx     = 4'(i);
      e.done    = 1'b0;
      return e;
   endfunction

   function automatic exp_t idle_entry(input logic d);
      exp_t e;
      e.note = N_NONE; e.playing = 1'b0; e.idx = 4'd0; e.done = d;
      return e;
   endfunction

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("note",    8'(note),    8'(e.note));
         chk("playing", 8'(playing), 8'(e.playing));
         chk("idx",     8'(idx),     8'(e.idx));
         chk("done",    8'(done),    8'(e.done));
      end
      if (exp_l_q.size() > 0) begin
         e = exp_l_q.pop_front();
         chk("loop_note",    8'(note_l),    8'(e.note));
         chk("loop_playing", 8'(playing_l), 8'(e.playing));
         chk("loop_idx",     8'(idx_l),     8'(e.idx));
         chk("loop_done",    8'(done_l),    8'(e.done));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; start_l = 1'b0; stop_l = 1'b0;
      step();
      // Reset state, even with start asserted.
      start = 1'b1; start_l = 1'b1;
      exp_q.push_back(idle_entry(1'b0));
      exp_l_q.push_back(idle_entry(1'b0));
      step();
      rst = 1'b0; start = 1'b0; start_l = 1'b0;
      step();

      // Full one-shot song; an async RESET glitch between edges must be ignored.
      for (int k = 1; k <= SONG; k++) exp_q.push_back(song_entry(k));
      exp_q.push_back(idle_entry(1'b1));
      exp_q.push_back(idle_entry(1'b0));
      exp_q.push_back(idle_entry(1'b0));
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= SONG + 3; k++) begin
         if (k == 50) begin
            rst = 1'b1; #2; rst = 1'b0;
         end
         if (k == 20) start = 1'b1;   // start while playing is ignored
         if (k == 21) start = 1'b0;
         step();
      end

      // Pause for 10 cycles from the 2nd cycle of idx 3.
      for (int k = 1; k <= SONG; k++) begin
         exp_q.push_back(song_entry(k));
         if (k == 20) for (int j = 0; j < 10; j++) exp_q.push_back(song_entry(20));
      end
      exp_q.push_back(idle_entry(1'b1));
      exp_q.push_back(idle_entry(1'b0));
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= SONG + 12; k++) begin
         pause = (k >= 21 && k <= 30);
         step();
      end
      pause = 1'b0;

      // Stop together with start mid idx 7, then replay with pause held in IDLE.
      for (int k = 1; k <= 44; k++) exp_q.push_back(song_entry(k));
      exp_q.push_back(idle_entry(1'b0));
      exp_q.push_back(idle_entry(1'b0));
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= 46; k++) begin
         start = (k == 45);
         stop  = (k == 45);
         step();
      end
      start = 1'b0; stop = 1'b0;
      for (int k = 1; k <= 8; k++) exp_q.push_back(song_entry(k));
      exp_q.push_back(idle_entry(1'b0));
      start = 1'b1; pause = 1'b1;
      step();
      start = 1'b0; pause = 1'b0;
      for (int k = 2; k <= 9; k++) begin
         stop = (k == 9);
         step();
      end
      stop = 1'b0;

      // Looping instance: wraps straight to E at idx 0, never pulses done.
      for (int k = 1; k <= SONG; k++) exp_l_q.push_back(song_entry(k));
      for (int k = 1; k <= 10; k++) exp_l_q.push_back(song_entry(k));
      exp_l_q.push_back(idle_entry(1'b0));
      start_l = 1'b1;
      step();
      start_l = 1'b0;
      for (int k = 2; k <= SONG + 11; k++) begin
         stop_l = (k == SONG + 11);
         step();
      end
      stop_l = 1'b0;

      // Synchronous RESET in the gap of idx 5: reset values next cycle, no done afterwards.
      for (int k = 1; k <= 35; k++) exp_q.push_back(song_entry(k));
      for (int k = 0; k < 10; k++) exp_q.push_back(idle_entry(1'b0));
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 2; k <= 45; k++) begin
         rst = (k == 36);
         step();
      end
      rst = 1'b0;

      chk("drain", 8'(exp_q.size() + exp_l_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
